// File: rtl/frame_buf_pkg.sv
// Shared constants for the ping-pong frame store: default geometry and mode tag encoding.
// No logic, no latency.
// No flow control here.
package frame_buf_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 16;

  // Per-frame mode tag carried alongside each committed frame
  localparam logic MODE_SMALL = 1'b0;
  localparam logic MODE_BIG   = 1'b1;

  // Word address width for a frame of the given depth (never narrower than one bit)
  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One DEPTH x DATA_W frame bank with single-word write port and whole-bank synchronous clear.
// Write lands on the rising edge; the flattened read bus is a direct register view.
// No backpressure: the owner gates the write enable.
module frame_bank
  import frame_buf_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       addr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    clr,
  output logic [DEPTH*DATA_W-1:0] rd_bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage: reset and clear zero every word; clear beats a same-cycle write
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[addr] <= wdata;
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_rd
    assign rd_bus[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: rtl/frame_pingpong_regfile.sv
// Double-buffered frame store: producer fills one bank while the other is presented in full.
// Commit at edge N is visible right after edge N when the presenting bank is the one committed.
// wr_ready drops while the fill bank still holds an unacked frame; optional macro FRAME_CLR_ON_RELEASE_EN zeroes a bank on release.
module frame_pingpong_regfile
  import frame_buf_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int CNT_W  = 16,
  localparam int ADDR_W = addr_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_valid,
  output logic                    wr_ready,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    wr_last,
  input  logic                    wr_mode,
  output logic                    frame_valid,
  output logic [DEPTH*DATA_W-1:0] frame_data,
  output logic                    frame_mode,
  input  logic                    frame_ack,
  output logic [CNT_W-1:0]        frame_cnt
);

  logic [1:0] full;
  logic [1:0] mode_tag;
  logic       wr_sel;
  logic       rd_sel;

  logic       wr_fire;
  logic       commit;
  logic       rel_fire;
  logic       addr_ok;
  logic [1:0] bank_we;
  logic [1:0] bank_clr;
  logic [DEPTH*DATA_W-1:0] bank_bus [2];

  assign wr_ready    = !full[wr_sel];
  assign wr_fire     = wr_valid && wr_ready;
  assign commit      = wr_fire && wr_last;
  assign rel_fire    = frame_ack && frame_valid;
  // Out-of-range beats are still accepted (and may commit) but store nothing
  assign addr_ok     = (32'(wr_addr) < 32'(DEPTH));

  assign frame_valid = full[rd_sel];
  assign frame_mode  = mode_tag[rd_sel];
  assign frame_data  = bank_bus[rd_sel];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    // The presented bank is full, so wr_ready keeps it from ever being written
    assign bank_we[b] = wr_fire && addr_ok && (wr_sel == 1'(b));
`ifdef FRAME_CLR_ON_RELEASE_EN
    assign bank_clr[b] = rel_fire && (rd_sel == 1'(b));
`else
    assign bank_clr[b] = 1'b0;
`endif

    frame_bank #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_bank (
      .clk    (clk),
      .rst    (rst),
      .we     (bank_we[b]),
      .addr   (wr_addr),
      .wdata  (wr_data),
      .clr    (bank_clr[b]),
      .rd_bus (bank_bus[b])
    );
  end

  // Bank status, fill/present pointers, mode tags and commit counter; commit and release always hit different banks
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= 2'b00;
      mode_tag  <= {MODE_SMALL, MODE_SMALL};
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (commit) begin
        full[wr_sel]     <= 1'b1;
        mode_tag[wr_sel] <= wr_mode;
        wr_sel           <= ~wr_sel;
        frame_cnt        <= frame_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      if (rel_fire) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= ~rd_sel;
      end
    end
  end

endmodule

// File: tb/tb_frame_pingpong_regfile.sv
// Directed bench for the ping-pong frame store with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Producer stalls are bounded by a cycle budget.
module tb_frame_pingpong_regfile;
  import frame_buf_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;
  localparam int CNT_W  = 16;
  localparam int ADDR_W = 4;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wr_valid;
  logic                    wr_ready;
  logic [ADDR_W-1:0]       wr_addr;
  logic [DATA_W-1:0]       wr_data;
  logic                    wr_last;
  logic                    wr_mode;
  logic                    frame_valid;
  logic [DEPTH*DATA_W-1:0] frame_data;
  logic                    frame_mode;
  logic                    frame_ack;
  logic [CNT_W-1:0]        frame_cnt;

  int n_checks = 0;
  int n_errors = 0;

  frame_pingpong_regfile #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_last     (wr_last),
    .wr_mode     (wr_mode),
    .frame_valid (frame_valid),
    .frame_data  (frame_data),
    .frame_mode  (frame_mode),
    .frame_ack   (frame_ack),
    .frame_cnt   (frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DATA_W-1:0] word(input int i);
    return frame_data[i*DATA_W +: DATA_W];
  endfunction

  // Present one beat and hold it until accepted (bounded)
  task automatic send(input int addr, input logic [DATA_W-1:0] data,
                      input logic last, input logic mode);
    int n = 0;
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(addr);
    wr_data  = data;
    wr_last  = last;
    wr_mode  = mode;
    while (!wr_ready && n < 20) begin
      step();
      n++;
    end
    if (!wr_ready) check("send_timeout", 64'(wr_ready), 64'(1));
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic ack_once();
    frame_ack = 1'b1;
    step();
    frame_ack = 1'b0;
  endtask

  logic [DATA_W-1:0] exp_w;

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    wr_last = 1'b0; wr_mode = 1'b0; frame_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_wr_ready",    64'(wr_ready),    64'(1));
    check("rst_frame_valid", 64'(frame_valid), 64'(0));
    check("rst_frame_data",  64'(|frame_data), 64'(0));
    check("rst_frame_mode",  64'(frame_mode),  64'(0));
    check("rst_frame_cnt",   64'(frame_cnt),   64'(0));

    // 1: first frame, big mode
    for (int i = 0; i < DEPTH; i++) send(i, 32'h100 + 32'(i), i == DEPTH-1, MODE_BIG);
    check("f1_valid", 64'(frame_valid), 64'(1));
    check("f1_mode",  64'(frame_mode),  64'(1));
    check("f1_cnt",   64'(frame_cnt),   64'(1));
    for (int i = 0; i < DEPTH; i++) check($sformatf("f1_word%0d", i), 64'(word(i)), 64'(32'h100 + 32'(i)));

    // 2: second frame fills the other bank while frame 1 stays presented
    for (int i = 0; i < DEPTH; i++) send(i, 32'h200 + 32'(i), i == DEPTH-1, MODE_SMALL);
    check("f2_cnt",      64'(frame_cnt),  64'(2));
    check("f2_wr_ready", 64'(wr_ready),   64'(0));
    check("f2_mode_hold", 64'(frame_mode), 64'(1));
    for (int i = 0; i < DEPTH; i++) check($sformatf("f2_hold_word%0d", i), 64'(word(i)), 64'(32'h100 + 32'(i)));

    // Third frame's first beat stalls
    wr_valid = 1'b1; wr_addr = 4'd0; wr_data = 32'h300; wr_last = 1'b0; wr_mode = 1'b0;
    step(); step();
    check("stall_wr_ready", 64'(wr_ready), 64'(0));
    check("stall_word0",    64'(word(0)),  64'(32'h100));
    check("stall_cnt",      64'(frame_cnt), 64'(2));

    // 3: ack frame 1 with the stalled beat still held
    ack_once();
    check("f3_valid",    64'(frame_valid), 64'(1));
    check("f3_wr_ready", 64'(wr_ready),    64'(1));
    check("f3_mode",     64'(frame_mode),  64'(0));
    for (int i = 0; i < DEPTH; i++) check($sformatf("f3_word%0d", i), 64'(word(i)), 64'(32'h200 + 32'(i)));
    step();   // stalled beat accepted into bank 0
    wr_valid = 1'b0;

    // 4: sparse frame into the reused bank
    send(3, 32'hABCD, 1'b1, MODE_BIG);
    check("f4_cnt", 64'(frame_cnt), 64'(3));
    ack_once();
    check("f4_valid", 64'(frame_valid), 64'(1));
    check("f4_mode",  64'(frame_mode),  64'(1));
    for (int i = 0; i < DEPTH; i++) begin
      if (i == 0)      exp_w = 32'h300;
      else if (i == 3) exp_w = 32'hABCD;
`ifdef FRAME_CLR_ON_RELEASE_EN
      else             exp_w = 32'h0;
`else
      else             exp_w = 32'h100 + 32'(i);
`endif
      check($sformatf("f4_word%0d", i), 64'(word(i)), 64'(exp_w));
    end

    // 5: reset in the middle of a frame
    for (int i = 0; i < 7; i++) send(i, 32'h500 + 32'(i), 1'b0, MODE_SMALL);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mrst_wr_ready", 64'(wr_ready),    64'(1));
    check("mrst_valid",    64'(frame_valid), 64'(0));
    check("mrst_cnt",      64'(frame_cnt),   64'(0));
    check("mrst_data",     64'(|frame_data), 64'(0));
    check("mrst_mode",     64'(frame_mode),  64'(0));
    send(2, 32'h11, 1'b0, MODE_SMALL);
    send(2, 32'h22, 1'b0, MODE_SMALL);
    send(5, 32'h55, 1'b1, MODE_SMALL);
    check("fresh_valid", 64'(frame_valid), 64'(1));
    check("fresh_cnt",   64'(frame_cnt),   64'(1));
    check("fresh_word0", 64'(word(0)),     64'(0));
    check("fresh_word2", 64'(word(2)),     64'(32'h22));
    check("fresh_word5", 64'(word(5)),     64'(32'h55));
    ack_once();
    check("fresh_released", 64'(frame_valid), 64'(0));

    // 6: counter wrap over 65537 one-beat frames, acking continuously
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr_valid = 1'b1; wr_addr = 4'd0; wr_last = 1'b1; wr_mode = 1'b0; frame_ack = 1'b1;
    for (int i = 0; i < 65537; i++) begin
      wr_data = 32'(i);
      step();
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    check("wrap_cnt",   64'(frame_cnt),   64'(1));
    check("wrap_valid", 64'(frame_valid), 64'(1));
    check("wrap_word0", 64'(word(0)),     64'(32'h10000));
    step();   // ack releases the final frame
    check("wrap_drained", 64'(frame_valid), 64'(0));
`ifdef FRAME_CLR_ON_RELEASE_EN
    exp_w = 32'h0;
`else
    exp_w = 32'hFFFF;
`endif
    step(); step();   // spurious acks with nothing presented
    frame_ack = 1'b0;
    check("spur_valid",    64'(frame_valid), 64'(0));
    check("spur_cnt",      64'(frame_cnt),   64'(1));
    check("spur_wr_ready", 64'(wr_ready),    64'(1));
    check("spur_word0",    64'(word(0)),     64'(exp_w));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
